demux_stream_n: RTL and testbench
=================================

# demux_stream_n

Parametrised, registered 1-to-N stream demultiplexer. It generalises the combinational 1-to-8 demux to N output channels of DATA_W-bit words, with a valid/ready handshake on every port and a one-word output register per channel. It adds a broadcast mode and counts words dropped because of out-of-range selects. It sits between a single producer and N independent consumers that may stall individually.

## Interface
- DATA_W, 8, data word width (≥1)
- N_OUT, 8, number of output channels (2..64)
- SEL_W, $clog2(N_OUT), select width (derived, do not override)
- CNT_W, 8, drop counter width

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  global accept enable; does not gate output draining
- in_valid  in  1  input word valid
- in_data  in  DATA_W  input word
- in_sel  in  SEL_W  target channel for unicast
- in_bcast  in  1  1 = broadcast to all channels; in_sel is ignored
- in_ready  out  1  input accept (combinational)
- out_valid  out  N_OUT  per-channel word valid
- out_data  out  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- out_ready  in  N_OUT  per-channel consumer ready
- drop_err  out  1  one-cycle pulse, one cycle after an out-of-range word is accepted
- drop_cnt  out  CNT_W  saturating count of dropped words

## Operation
- Each channel k has a one-word buffer with two states, EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
- can_take[k] = !out_valid[k] | out_ready[k]. A FULL buffer draining this cycle accepts a new word in the same cycle.
- A transfer occurs when in_valid & in_ready.
- Unicast, in_sel < N_OUT: in_ready = enable & can_take[in_sel]. On transfer, buffer in_sel loads in_data and becomes FULL.
- Unicast, in_sel ≥ N_OUT (only possible when N_OUT is not a power of 2): in_ready = enable. The word is accepted and discarded. drop_err pulses and drop_cnt increments, saturating at 2^CNT_W−1.
- Broadcast: in_ready = enable & (AND of can_take over all k). On transfer, every buffer loads in_data and becomes FULL in the same cycle. Partial delivery never occurs.
- Output drain: a handshake out_valid[k] & out_ready[k] with no new load makes buffer k EMPTY. Load and drain in the same cycle leaves it FULL with the new word.
- out_data[k] holds its value while FULL and out_ready[k]=0. When EMPTY, out_data[k] retains the last value and must be treated as don't-care.
- enable=0: in_ready=0. Buffers still drain normally. No counter change.
- in_ready depends on in_valid only through nothing: it is a function of enable, in_sel, in_bcast, out_valid and out_ready. Producers may observe in_ready before asserting in_valid.
- Channels are independent. A stall on one channel blocks only unicasts to that channel and all broadcasts.

## Timing
- Reset (rst_n=0, asynchronous assert, synchronous release on the next clk edge): out_valid=0, out_data=0, drop_err=0, drop_cnt=0. Buffered words are discarded without delivery. in_ready=0 while in reset.
- Latency: a word accepted on edge t is visible on out_valid/out_data after edge t. It can be consumed on edge t+1.
- Throughput: one word per cycle per input when the target channel is ready. Back-to-back unicasts to one channel with out_ready held at 1 sustain 1 word/cycle.
- drop_err is high for exactly the cycle after each dropped-word accept. Consecutive drops hold it high continuously.
- drop_cnt updates on the same edge that sets drop_err.
- No combinational path from in_valid or in_data to any output. The only combinational paths are out_ready/in_sel/in_bcast/enable → in_ready.

## Test plan
- Reset mid-traffic: fill channels 0 and 3 with 0xA5/0x3C, assert rst_n=0 asynchronously → out_valid=0x00, out_data all 0, drop_cnt=0 immediately, no later delivery.
- Unicast fan-out (N_OUT=8, all out_ready=1): send 0x10..0x17 with in_sel=0..7 back-to-back → channel k presents 0x10+k exactly one cycle after accept, in_ready stays 1, 8 words in 8 cycles.
- Backpressure: out_ready[2]=0, send 0x55 then 0x66 to sel=2 → 0x55 held, in_ready=0 for the second word. Raise out_ready[2] → 0x55 consumed and 0x66 loaded on the same edge, no bubble.
- Broadcast blocking: channel 5 FULL with out_ready[5]=0, in_bcast=1 with 0x99 → in_ready=0 and no channel loads. Release channel 5 → all 8 channels present 0x99 in the same cycle.
- Out-of-range (N_OUT=6, CNT_W=2): send 5 words with in_sel=6 or 7 → each accepted, drop_err high 5 consecutive cycles, drop_cnt 1,2,3,3,3, out_valid unchanged.
- Enable gating: enable=0 with in_valid=1 and FULL channels draining → in_ready=0, drains complete, drop_cnt unchanged. Set enable=1 → the pending word is accepted next edge.

Source files
------------

// File: rtl/demux_stream_n.sv
// demux_stream_n: registered 1-to-N valid/ready stream demultiplexer.
// Each channel owns a one-word output buffer. The input can unicast to one
// channel or broadcast to all of them. Words addressed to a nonexistent
// channel are accepted and discarded, and a saturating counter tracks them.
module demux_stream_n #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = $clog2(N_OUT),
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  output logic                    in_ready,
  output logic [N_OUT-1:0]        out_valid,
  output logic [N_OUT*DATA_W-1:0] out_data,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    drop_err,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SEL_W:0]   N_OUT_W = (SEL_W+1)'(N_OUT);

  logic [N_OUT-1:0]        out_valid_q, out_valid_d;
  logic [N_OUT*DATA_W-1:0] out_data_q, out_data_d;
  logic                    drop_err_q, drop_err_d;
  logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;

  logic [N_OUT-1:0] can_take;
  logic [N_OUT-1:0] load;
  logic             sel_in_range;
  logic             xfer;
  logic             drop;

  // A buffer can take a word when it is empty or is being drained this cycle.
  assign can_take     = ~out_valid_q | out_ready;
  assign sel_in_range = ({1'b0, in_sel} < N_OUT_W);
  assign xfer         = in_valid & in_ready;
  assign drop         = xfer & ~in_bcast & ~sel_in_range;

  // Input acceptance depends only on the mode, the target buffers and enable;
  // holding it low in reset keeps the producer from seeing a spurious accept.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && enable) begin
      if (in_bcast) begin
        in_ready = &can_take;
      end else if (sel_in_range) begin
        in_ready = can_take[in_sel];
      end else begin
        in_ready = 1'b1;
      end
    end
  end

  // Next buffer state: load on transfer to this channel, otherwise drain on handshake.
  always_comb begin
    load        = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    for (int k = 0; k < N_OUT; k++) begin
      load[k] = xfer & (in_bcast | (sel_in_range & (in_sel == SEL_W'(k))));
      if (load[k]) begin
        out_valid_d[k]                     = 1'b1;
        out_data_d[k*DATA_W +: DATA_W]     = in_data;
      end else if (out_valid_q[k] && out_ready[k]) begin
        out_valid_d[k]                     = 1'b0;
      end
    end
  end

  // Drop reporting: one-cycle pulse per dropped word and a saturating tally.
  always_comb begin
    drop_err_d = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // State registers; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      drop_err_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      drop_err_q  <= drop_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign drop_err  = drop_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_n.sv
// tb_demux_stream_n: scenario tasks plus a randomized run against a
// channel-level behavioural model (one word slot per channel, an integer
// drop tally clamped at its maximum).
module tb_demux_stream_n;

  localparam int DATA_W = 8;
  localparam int N_OUT  = 6;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 2;
  localparam int CNT_MX = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    enable;
  logic                    in_valid;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_bcast;
  logic                    in_ready;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_ready;
  logic                    drop_err;
  logic [CNT_W-1:0]        drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  bit                mv[N_OUT];
  logic [DATA_W-1:0] md[N_OUT];
  bit                m_err;
  int                m_cnt;

  demux_stream_n #(.DATA_W(DATA_W), .N_OUT(N_OUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .drop_err(drop_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_ready();
    bit r;
    if (!rst_n || !enable) return 1'b0;
    if (in_bcast) begin
      r = 1'b1;
      for (int k = 0; k < N_OUT; k++) if (mv[k] && !out_ready[k]) r = 1'b0;
      return r;
    end
    if (int'(in_sel) >= N_OUT) return 1'b1;
    return !mv[in_sel] || out_ready[in_sel];
  endfunction

  function automatic logic [N_OUT-1:0] m_vvec();
    logic [N_OUT-1:0] v;
    for (int k = 0; k < N_OUT; k++) v[k] = mv[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N_OUT; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
    end
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    bit                xfer;
    bit                bc;
    int                sel;
    logic [DATA_W-1:0] dat;
    logic [N_OUT-1:0]  ordy;
    xfer = in_valid && m_ready();
    bc   = in_bcast;
    sel  = int'(in_sel);
    dat  = in_data;
    ordy = out_ready;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int k = 0; k < N_OUT; k++) if (mv[k] && ordy[k]) mv[k] = 1'b0;
      m_err = 1'b0;
      if (xfer) begin
        if (bc) begin
          for (int k = 0; k < N_OUT; k++) begin
            mv[k] = 1'b1;
            md[k] = dat;
          end
        end else if (sel < N_OUT) begin
          mv[sel] = 1'b1;
          md[sel] = dat;
        end else begin
          m_err = 1'b1;
          if (m_cnt < CNT_MX) m_cnt++;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_bcast = 1'b0;
    in_sel   = '0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    enable    = 1'b1;
    out_ready = '1;
    idle_inputs();
    model_clear();
    #2;
    n_cmp += 5;
    if (out_valid !== '0) begin n_fail++; $display("[TB] FAIL reset_valid got %h want 0", out_valid); end
    if (out_data !== '0) begin n_fail++; $display("[TB] FAIL reset_data got %h want 0", out_data); end
    if (drop_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got %b want 0", drop_err); end
    if (drop_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset_cnt got %0d want 0", drop_cnt); end
    if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 0", in_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_traffic();
    out_ready = '0;
    in_valid  = 1'b1;
    in_sel    = 3'd0;
    in_data   = 8'hA5;
    tick();
    in_sel  = 3'd3;
    in_data = 8'h3C;
    tick();
    idle_inputs();
    n_cmp += 2;
    if (out_valid !== 6'b001001) begin n_fail++; $display("[TB] FAIL mid_fill_valid got %b want 001001", out_valid); end
    if ({out_data[3*8 +: 8], out_data[0 +: 8]} !== 16'h3CA5) begin
      n_fail++; $display("[TB] FAIL mid_fill_data got %h want 3ca5", {out_data[3*8 +: 8], out_data[0 +: 8]});
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    n_cmp += 3;
    if (out_valid !== '0) begin n_fail++; $display("[TB] FAIL async_rst_valid got %b want 0", out_valid); end
    if (out_data !== '0) begin n_fail++; $display("[TB] FAIL async_rst_data got %h want 0", out_data); end
    if (drop_cnt !== '0) begin n_fail++; $display("[TB] FAIL async_rst_cnt got %0d want 0", drop_cnt); end
    tick();
    rst_n     = 1'b1;
    out_ready = '1;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== '0) begin n_fail++; $display("[TB] FAIL post_rst_valid got %b want 0", out_valid); end
  endtask

  task automatic test_fanout();
    out_ready = '1;
    in_valid  = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      in_sel  = SEL_W'(k);
      in_data = DATA_W'(8'h10 + k);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fanout_ready[%0d] got %b want 1", k, in_ready); end
      tick();
      n_cmp += 2;
      if (out_valid !== N_OUT'(1 << k)) begin
        n_fail++; $display("[TB] FAIL fanout_valid[%0d] got %b want %b", k, out_valid, N_OUT'(1 << k));
      end
      if (out_data[k*8 +: 8] !== DATA_W'(8'h10 + k)) begin
        n_fail++; $display("[TB] FAIL fanout_data[%0d] got %h want %h", k, out_data[k*8 +: 8], 8'h10 + k);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 6'b111011;
    in_valid  = 1'b1;
    in_sel    = 3'd2;
    in_data   = 8'h55;
    tick();
    in_data = 8'h66;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_stalled got %b want 0", in_ready); end
    tick();
    n_cmp += 2;
    if (out_valid[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold_valid got %b want 1", out_valid[2]); end
    if (out_data[2*8 +: 8] !== 8'h55) begin n_fail++; $display("[TB] FAIL bp_hold_data got %h want 55", out_data[2*8 +: 8]); end
    out_ready = '1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_release got %b want 1", in_ready); end
    tick();
    n_cmp += 2;
    if (out_valid[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_swap_valid got %b want 1", out_valid[2]); end
    if (out_data[2*8 +: 8] !== 8'h66) begin n_fail++; $display("[TB] FAIL bp_swap_data got %h want 66", out_data[2*8 +: 8]); end
    idle_inputs();
    tick();
    n_cmp++;
    if (out_valid !== '0) begin n_fail++; $display("[TB] FAIL bp_drained got %b want 0", out_valid); end
  endtask

  task automatic test_bcast_block();
    out_ready = 6'b011111;
    in_valid  = 1'b1;
    in_sel    = 3'd5;
    in_data   = 8'h77;
    tick();
    in_bcast = 1'b1;
    in_sel   = 3'd1;
    in_data  = 8'h99;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bc_ready_blocked got %b want 0", in_ready); end
    tick();
    n_cmp += 2;
    if (out_valid !== 6'b100000) begin n_fail++; $display("[TB] FAIL bc_no_partial got %b want 100000", out_valid); end
    if (out_data[5*8 +: 8] !== 8'h77) begin n_fail++; $display("[TB] FAIL bc_hold5 got %h want 77", out_data[5*8 +: 8]); end
    out_ready = '1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bc_ready_release got %b want 1", in_ready); end
    tick();
    n_cmp += 2;
    if (out_valid !== 6'b111111) begin n_fail++; $display("[TB] FAIL bc_all_valid got %b want 111111", out_valid); end
    if (out_data !== {N_OUT{8'h99}}) begin n_fail++; $display("[TB] FAIL bc_all_data got %h want all 99", out_data); end
    idle_inputs();
    tick();
  endtask

  task automatic test_out_of_range();
    int exp_cnt[5] = '{1, 2, 3, 3, 3};
    out_ready = 6'b111101;
    in_valid  = 1'b1;
    in_sel    = 3'd1;
    in_data   = 8'h42;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_sel  = SEL_W'(6 + (i % 2));
      in_data = DATA_W'($urandom);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      n_cmp += 4;
      if (drop_err !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_err[%0d] got %b want 1", i, drop_err); end
      if (drop_cnt !== CNT_W'(exp_cnt[i])) begin n_fail++; $display("[TB] FAIL oor_cnt[%0d] got %0d want %0d", i, drop_cnt, exp_cnt[i]); end
      if (out_valid !== 6'b000010) begin n_fail++; $display("[TB] FAIL oor_valid[%0d] got %b want 000010", i, out_valid); end
      if (out_data[1*8 +: 8] !== 8'h42) begin n_fail++; $display("[TB] FAIL oor_data[%0d] got %h want 42", i, out_data[1*8 +: 8]); end
    end
    idle_inputs();
    tick();
    n_cmp += 2;
    if (drop_err !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_err_end got %b want 0", drop_err); end
    if (drop_cnt !== CNT_W'(CNT_MX)) begin n_fail++; $display("[TB] FAIL oor_cnt_end got %0d want 3", drop_cnt); end
  endtask

  task automatic test_enable();
    out_ready = '0;
    in_valid  = 1'b1;
    in_sel    = 3'd0;
    in_data   = 8'h11;
    tick();
    in_sel  = 3'd4;
    in_data = 8'h44;
    tick();
    enable    = 1'b0;
    out_ready = '1;
    in_sel    = 3'd2;
    in_data   = 8'hE7;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL en_ready_off got %b want 0", in_ready); end
    tick();
    n_cmp += 2;
    if (out_valid !== '0) begin n_fail++; $display("[TB] FAIL en_drain got %b want 0", out_valid); end
    if (drop_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("[TB] FAIL en_cnt got %0d want %0d", drop_cnt, m_cnt); end
    enable = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL en_ready_on got %b want 1", in_ready); end
    tick();
    n_cmp += 2;
    if (out_valid !== 6'b000100) begin n_fail++; $display("[TB] FAIL en_accept_valid got %b want 000100", out_valid); end
    if (out_data[2*8 +: 8] !== 8'hE7) begin n_fail++; $display("[TB] FAIL en_accept_data got %h want e7", out_data[2*8 +: 8]); end
    idle_inputs();
    tick();
  endtask

  task automatic test_random(input int cycles);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    tick();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < cycles; c++) begin
      enable    = ($urandom_range(0, 7) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bcast  = ($urandom_range(0, 7) == 0);
      in_sel    = SEL_W'($urandom_range(0, 7));
      in_data   = DATA_W'($urandom);
      out_ready = N_OUT'($urandom);
      #1;
      n_cmp++;
      if (in_ready !== m_ready()) begin n_fail++; $display("[TB] FAIL rnd_ready cyc %0d got %b want %b", c, in_ready, m_ready()); end
      tick();
      n_cmp += 3;
      if (out_valid !== m_vvec()) begin n_fail++; $display("[TB] FAIL rnd_valid cyc %0d got %b want %b", c, out_valid, m_vvec()); end
      if (drop_err !== m_err) begin n_fail++; $display("[TB] FAIL rnd_err cyc %0d got %b want %b", c, drop_err, m_err); end
      if (drop_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("[TB] FAIL rnd_cnt cyc %0d got %0d want %0d", c, drop_cnt, m_cnt); end
      for (int k = 0; k < N_OUT; k++) begin
        if (mv[k]) begin
          n_cmp++;
          if (out_data[k*8 +: 8] !== md[k]) begin
            n_fail++; $display("[TB] FAIL rnd_data[%0d] cyc %0d got %h want %h", k, c, out_data[k*8 +: 8], md[k]);
          end
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_traffic();
    test_fanout();
    test_backpressure();
    test_bcast_block();
    test_out_of_range();
    test_enable();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
